// File: rtl/zeta_stream_reader.sv
// ---------------------------------------------------------------------------
// zeta_stream_reader
//
// Walks the packed twiddle-factor ROM (32 words x four 12-bit zetas) and
// streams one twiddle per cycle to the butterfly datapath. Forward passes
// run addr 0->31 / lane 0->3. Inverse passes run addr 31->0 / lane 3->0 and
// emit (Q - zeta) mod Q.
//
// The ROM has one cycle of read latency. Two word registers hide it:
// cur (being emitted) and nxt (prefetched).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, inv           start a 128-twiddle pass; inv latched with start
//   flush                synchronous abort, highest priority after rst_n
//   rom_addr, rom_data   registered ROM address / read data (next cycle)
//   tw_data, tw_idx      twiddle value and its table position
//   tw_last              final twiddle of the pass
//   tw_valid, tw_ready   valid/ready handshake towards the consumer
//   busy                 pass in progress
//   done                 one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module zeta_stream_reader #(
    parameter int DATA_WIDTH = 48,
    parameter int Q          = 3329
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  inv,
    input  logic                  flush,
    output logic [4:0]            rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [11:0]           tw_data,
    output logic [6:0]            tw_idx,
    output logic                  tw_last,
    output logic                  tw_valid,
    input  logic                  tw_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int         LANE_W = 12;
    localparam logic [11:0] Q12   = 12'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM
    } state_t;

    state_t                state_q, state_d;
    logic                  inv_q, inv_d;
    logic [4:0]            rom_addr_q, rom_addr_d;
    logic [4:0]            next_addr_q, next_addr_d;     // address of the next prefetch
    logic [5:0]            words_left_q, words_left_d;   // words not yet requested
    logic                  req_q, req_d;                 // address presented this cycle
    logic                  rsp_q, rsp_d;                 // rom_data valid this cycle
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0] nxt_q, nxt_d;
    logic                  cur_full_q, cur_full_d;
    logic                  nxt_full_q, nxt_full_d;
    logic [4:0]            cur_addr_q, cur_addr_d;
    logic [4:0]            nxt_addr_q, nxt_addr_d;
    logic [1:0]            lane_q, lane_d;               // physical lane of cur being emitted
    logic                  done_q, done_d;

    logic                  valid_w;
    logic                  hs_w;
    logic                  final_lane_w;
    logic                  last_w;
    logic [1:0]            first_lane_w;
    logic [LANE_W-1:0]     zeta_w;

    // Lane k sits at rom_data[47-12k -: 12].
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        zeta_w = '0;
        case (lane_q)
            2'd0:    zeta_w = cur_q[DATA_WIDTH-1            -: LANE_W];
            2'd1:    zeta_w = cur_q[DATA_WIDTH-1-LANE_W     -: LANE_W];
            2'd2:    zeta_w = cur_q[DATA_WIDTH-1-2*LANE_W   -: LANE_W];
            default: zeta_w = cur_q[DATA_WIDTH-1-3*LANE_W   -: LANE_W];
        endcase
    end

    assign valid_w      = (state_q == S_STREAM) && cur_full_q;
    assign hs_w         = valid_w && tw_ready;
    assign first_lane_w = inv_q ? 2'd3 : 2'd0;
    assign final_lane_w = inv_q ? (lane_q == 2'd0) : (lane_q == 2'd3);
    assign last_w       = valid_w && final_lane_w &&
                          (inv_q ? (cur_addr_q == 5'd0) : (cur_addr_q == 5'd31));

    assign rom_addr = rom_addr_q;
    assign tw_data  = (inv_q && zeta_w != '0) ? (Q12 - zeta_w) : zeta_w;
    assign tw_idx   = {cur_addr_q, lane_q};
    assign tw_last  = last_w;
    assign tw_valid = valid_w;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    always_comb begin
        state_d      = state_q;
        inv_d        = inv_q;
        rom_addr_d   = rom_addr_q;
        next_addr_d  = next_addr_q;
        words_left_d = words_left_q;
        req_d        = 1'b0;
        rsp_d        = 1'b0;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        cur_full_d   = cur_full_q;
        nxt_full_d   = nxt_full_q;
        cur_addr_d   = cur_addr_q;
        nxt_addr_d   = nxt_addr_q;
        lane_d       = lane_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    inv_d        = inv;
                    rom_addr_d   = inv ? 5'd31 : 5'd0;
                    next_addr_d  = inv ? 5'd30 : 5'd1;
                    words_left_d = 6'd31;
                    req_d        = 1'b1;
                    state_d      = S_FILL;
                end
            end

            default: begin
                rsp_d = req_q;

                // Consumer side: step through lanes, release cur after its final lane.
                if (hs_w) begin
                    if (final_lane_w) begin
                        cur_full_d = 1'b0;
                    end else begin
                        lane_d = inv_q ? lane_q - 2'd1 : lane_q + 2'd1;
                    end
                end
                if (hs_w && final_lane_w && nxt_full_q) begin
                    cur_d      = nxt_q;
                    cur_addr_d = nxt_addr_q;
                    cur_full_d = 1'b1;
                    nxt_full_d = 1'b0;
                    lane_d     = first_lane_w;
                end

                // ROM response: fill cur if it is free, otherwise nxt. During a
                // response cycle rom_addr_q still holds the responding address
                // because only one read is ever in flight.
                if (rsp_q) begin
                    if (!cur_full_d) begin
                        cur_d      = rom_data;
                        cur_addr_d = rom_addr_q;
                        cur_full_d = 1'b1;
                        lane_d     = first_lane_w;
                    end else begin
                        nxt_d      = rom_data;
                        nxt_addr_d = rom_addr_q;
                        nxt_full_d = 1'b1;
                    end
                end

                // Prefetch once a slot will be free and nothing is in flight.
                if (!req_q && words_left_q != 6'd0 && !(cur_full_d && nxt_full_d)) begin
                    rom_addr_d   = next_addr_q;
                    next_addr_d  = inv_q ? next_addr_q - 5'd1 : next_addr_q + 5'd1;
                    words_left_d = words_left_q - 6'd1;
                    req_d        = 1'b1;
                end

                if (state_q == S_FILL && rsp_q) begin
                    state_d = S_STREAM;
                end

                if (hs_w && last_w) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    cur_full_d = 1'b0;
                    nxt_full_d = 1'b0;
                    req_d      = 1'b0;
                    rsp_d      = 1'b0;
                end
            end
        endcase

        if (flush) begin
            state_d    = S_IDLE;
            cur_full_d = 1'b0;
            nxt_full_d = 1'b0;
            req_d      = 1'b0;
            rsp_d      = 1'b0;
            done_d     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the word registers are reset too, not just the flags:
            // tw_data and tw_idx are decoded from them and must read 0 in reset.
            state_q      <= S_IDLE;
            inv_q        <= 1'b0;
            rom_addr_q   <= '0;
            next_addr_q  <= '0;
            words_left_q <= '0;
            req_q        <= 1'b0;
            rsp_q        <= 1'b0;
            cur_q        <= '0;
            nxt_q        <= '0;
            cur_full_q   <= 1'b0;
            nxt_full_q   <= 1'b0;
            cur_addr_q   <= '0;
            nxt_addr_q   <= '0;
            lane_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            inv_q        <= inv_d;
            rom_addr_q   <= rom_addr_d;
            next_addr_q  <= next_addr_d;
            words_left_q <= words_left_d;
            req_q        <= req_d;
            rsp_q        <= rsp_d;
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            cur_full_q   <= cur_full_d;
            nxt_full_q   <= nxt_full_d;
            cur_addr_q   <= cur_addr_d;
            nxt_addr_q   <= nxt_addr_d;
            lane_q       <= lane_d;
            done_q       <= done_d;
        end
    end

endmodule
